// File: rtl/snn_pkg.sv
// Shared types and default sizes for the neuromorphic core scheduler and its LIF update.
// The state encoding is pinned by localparams so waveforms decode the same everywhere.
package snn_pkg;

  localparam int MAX_NEURONS_DEF = 8;
  localparam int WIDTH_DEF       = 32;
  localparam int STEP_W_DEF      = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_FIRE = 3'd3;
  localparam logic [2:0] ST_EMIT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN  = ST_RUN,
    FIRE = ST_FIRE,
    EMIT = ST_EMIT,
    DONE = ST_DONE
  } sched_state_t;

  typedef logic signed [WIDTH_DEF-1:0] mem_t;

endpackage

// File: rtl/core_scheduler_if.sv
// Bundle of the host/router handshakes and the core-facing bus of one scheduler.
// The master modport is the scheduler; slave is the host, router and core side.
interface core_scheduler_if
  import snn_pkg::*;
#(
  parameter int MAX_NEURONS = MAX_NEURONS_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int STEP_W      = STEP_W_DEF
);

  logic                    start;
  logic [STEP_W-1:0]       num_steps;
  logic                    in_valid;
  logic                    in_ready;
  logic [MAX_NEURONS-1:0]  in_spk;
  logic                    core_enable;
  logic [MAX_NEURONS-1:0]  core_spk_in;
  logic signed [WIDTH-1:0] core_mem_in  [MAX_NEURONS];
  logic signed [WIDTH-1:0] core_mem_out [MAX_NEURONS];
  logic                    core_done;
  logic                    out_valid;
  logic                    out_ready;
  logic [MAX_NEURONS-1:0]  out_spk;
  logic                    busy;
  logic                    run_done;
  logic                    err_timeout;

  modport master (
    input  start, num_steps, in_valid, in_spk, core_mem_out, core_done, out_ready,
    output in_ready, core_enable, core_spk_in, core_mem_in, out_valid, out_spk,
           busy, run_done, err_timeout
  );

  modport slave (
    output start, num_steps, in_valid, in_spk, core_mem_out, core_done, out_ready,
    input  in_ready, core_enable, core_spk_in, core_mem_in, out_valid, out_spk,
           busy, run_done, err_timeout
  );

endinterface

// File: rtl/lif_update.sv
// Combinational leaky integrate-and-fire step for a single neuron.
// Fires and resets at or above threshold, otherwise leaks by an arithmetic shift and clamps at zero.
module lif_update #(
  parameter int WIDTH      = 32,
  parameter int THRESH     = 32,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [WIDTH-1:0] mem,
  output logic signed [WIDTH-1:0] next_mem,
  output logic                    spike
);

  localparam logic signed [WIDTH-1:0] ThreshVal = WIDTH'(THRESH);

  logic signed [WIDTH-1:0] leaked;

  always_comb begin
    spike  = (mem >= ThreshVal);
    leaked = mem - (mem >>> LEAK_SHIFT);
    if (spike || leaked[WIDTH-1]) begin
      next_mem = '0;
    end else begin
      next_mem = leaked;
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Timestep sequencer for one crossbar core: loads a spike vector, runs the core,
// then applies the LIF threshold/leak and hands the fired vector downstream.
module core_scheduler
  import snn_pkg::*;
#(
  parameter int MAX_NEURONS = MAX_NEURONS_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int THRESH      = 32,
  parameter int LEAK_SHIFT  = 3,
  parameter int TIMEOUT     = 64,
  parameter int STEP_W      = STEP_W_DEF
) (
  input logic              clk,
  input logic              rst,
  core_scheduler_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  sched_state_t            state_q;
  logic [STEP_W-1:0]       step_q;
  logic [STEP_W-1:0]       numSteps_q;
  logic [CNT_W-1:0]        runCnt_q;
  logic signed [WIDTH-1:0] mem_q [MAX_NEURONS];
  logic [MAX_NEURONS-1:0]  coreSpk_q;
  logic [MAX_NEURONS-1:0]  outSpk_q;
  logic                    inReady_q;
  logic                    coreEn_q;
  logic                    outValid_q;
  logic                    busy_q;
  logic                    runDone_q;
  logic                    errTimeout_q;

  logic signed [WIDTH-1:0] memNext_d [MAX_NEURONS];
  logic [MAX_NEURONS-1:0]  spkNext_d;

  for (genvar n = 0; n < MAX_NEURONS; n++) begin : g_lif
    lif_update #(
      .WIDTH      (WIDTH),
      .THRESH     (THRESH),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lif (
      .mem      (mem_q[n]),
      .next_mem (memNext_d[n]),
      .spike    (spkNext_d[n])
    );
  end

  // The first RUN cycle ignores core_done since the core may still show the previous step's flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      step_q       <= '0;
      numSteps_q   <= '0;
      runCnt_q     <= '0;
      mem_q        <= '{default: '0};
      coreSpk_q    <= '0;
      outSpk_q     <= '0;
      inReady_q    <= 1'b0;
      coreEn_q     <= 1'b0;
      outValid_q   <= 1'b0;
      busy_q       <= 1'b0;
      runDone_q    <= 1'b0;
      errTimeout_q <= 1'b0;
    end else begin
      runDone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            errTimeout_q <= 1'b0;
            step_q       <= '0;
            if (bus.num_steps == '0) begin
              runDone_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              numSteps_q <= bus.num_steps;
              mem_q      <= '{default: '0};
              busy_q     <= 1'b1;
              inReady_q  <= 1'b1;
              state_q    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            coreSpk_q <= bus.in_spk;
            inReady_q <= 1'b0;
            coreEn_q  <= 1'b1;
            runCnt_q  <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if ((runCnt_q != '0) && bus.core_done) begin
            mem_q    <= bus.core_mem_out;
            coreEn_q <= 1'b0;
            state_q  <= FIRE;
          end else if (runCnt_q == CNT_W'(TIMEOUT - 1)) begin
            errTimeout_q <= 1'b1;
            coreEn_q     <= 1'b0;
            runDone_q    <= 1'b1;
            busy_q       <= 1'b0;
            step_q       <= '0;
            state_q      <= IDLE;
          end else begin
            runCnt_q <= runCnt_q + 1'b1;
          end
        end
        FIRE: begin
          mem_q      <= memNext_d;
          outSpk_q   <= spkNext_d;
          outValid_q <= 1'b1;
          state_q    <= EMIT;
        end
        EMIT: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            if (step_q == numSteps_q - 1'b1) begin
              busy_q    <= 1'b0;
              runDone_q <= 1'b1;
              step_q    <= '0;
              state_q   <= DONE;
            end else begin
              step_q    <= step_q + 1'b1;
              inReady_q <= 1'b1;
              state_q   <= LOAD;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = inReady_q;
  assign bus.core_enable = coreEn_q;
  assign bus.core_spk_in = coreSpk_q;
  assign bus.core_mem_in = mem_q;
  assign bus.out_valid   = outValid_q;
  assign bus.out_spk     = outSpk_q;
  assign bus.busy        = busy_q;
  assign bus.run_done    = runDone_q;
  assign bus.err_timeout = errTimeout_q;

endmodule
